// File: rtl/dma_read_src_engine.sv
// dma_read_src_engine
//
// Source-side read engine of the DMA datapath. It pops one descriptor and
// issues AXI4 INCR read bursts to source memory. Bursts are split so that
// none crosses a 4 KB page and none is longer than 64 beats. Returned beats
// pass unmodified into the data FIFO that the destination write FSM drains.
// Completion, busy, sticky error and two performance counters go to the
// CSR block.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   desc_*              descriptor FIFO status, fields and pop strobe
//   ar*                 AXI4 read address channel (one burst outstanding)
//   r*                  AXI4 read data channel
//   fifo_*              data FIFO push interface and back-pressure
//   rd_fsm_done         one-cycle pulse when a descriptor completes
//   busy                descriptor in progress (including DONE and ERROR)
//   error, clear_error  sticky read error and its release
//   rd_clk_cnt          saturating count of ADDR/DATA cycles for this descriptor
//   rd_beat_cnt         saturating count of beats pushed for this descriptor

module dma_read_src_engine #(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 64,
    parameter int LENGTH_W    = 24,
    parameter int PERF_CNTR_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   desc_not_empty,
    input  logic                   desc_go,
    input  logic [ADDR_W-1:0]      desc_src_addr,
    input  logic [LENGTH_W-1:0]    desc_length,
    output logic                   desc_rd_en,

    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_W-1:0]      araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    output logic [1:0]             arburst,

    input  logic                   rvalid,
    output logic                   rready,
    input  logic [DATA_W-1:0]      rdata,
    input  logic [1:0]             rresp,
    input  logic                   rlast,

    output logic                   fifo_wr_en,
    output logic [DATA_W-1:0]      fifo_wr_data,
    input  logic                   fifo_full,

    output logic                   rd_fsm_done,
    output logic                   busy,
    output logic                   error,
    input  logic                   clear_error,
    output logic [PERF_CNTR_W-1:0] rd_clk_cnt,
    output logic [PERF_CNTR_W-1:0] rd_beat_cnt
);

    localparam int BPB        = DATA_W / 8;
    localparam int BPB_LOG2   = $clog2(BPB);
    localparam int PAGE_BEATS = 4096 / BPB;
    localparam int BURST_W    = $clog2(PAGE_BEATS) + 1;
    localparam int PAGE_IDX_W = 12 - BPB_LOG2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_W-1:0]      cur_addr;
    logic [LENGTH_W-1:0]    remaining;
    logic [7:0]             beat_idx;
    logic [7:0]             exp_last;
    logic                   draining;
    logic                   error_q;

    logic [PAGE_IDX_W-1:0]  page_idx;
    logic [BURST_W-1:0]     page_room;
    logic [BURST_W-1:0]     burst;
    logic [7:0]             burst_arlen;
    logic                   accept;
    logic                   beat_bad;

    assign arsize  = 3'(BPB_LOG2);
    assign arburst = 2'b01;
    assign error   = error_q;

    // The beats left before the next 4 KB page boundary cap the burst. A
    // page holds exactly 64 beats, so this cap also enforces the 64-beat
    // maximum.
    always_comb begin
        page_idx    = cur_addr[11:BPB_LOG2];
        page_room   = BURST_W'(PAGE_BEATS) - BURST_W'(page_idx);
        burst       = (remaining < LENGTH_W'(page_room)) ? BURST_W'(remaining) : page_room;
        burst_arlen = 8'(burst - BURST_W'(1));
    end

    // A beat is bad if the slave flagged it, or if rlast disagrees with the
    // beat position expected from the arlen issued.
    always_comb begin
        accept   = rvalid & rready;
        beat_bad = (rresp != 2'b00) || (rlast != (beat_idx == exp_last));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and outputs decoded from the current state. Every output is
    // forced low while reset is held, so a descriptor cannot be popped and
    // lost during reset.
    always_comb begin
        state_next   = state;
        desc_rd_en   = 1'b0;
        arvalid      = 1'b0;
        araddr       = '0;
        arlen        = '0;
        rready       = 1'b0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        rd_fsm_done  = 1'b0;
        busy         = 1'b0;

        case (state)
            S_IDLE: begin
                if (desc_not_empty && desc_go) begin
                    desc_rd_en = 1'b1;
                    state_next = (desc_length == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                busy    = 1'b1;
                arvalid = 1'b1;
                araddr  = cur_addr;
                arlen   = burst_arlen;
                if (arready) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                busy         = 1'b1;
                rready       = !fifo_full;
                fifo_wr_data = rdata;
                if (rvalid && !fifo_full) begin
                    if (beat_bad) begin
                        state_next = S_ERROR;
                    end else begin
                        fifo_wr_en = 1'b1;
                        if (rlast) begin
                            state_next = (remaining != '0) ? S_ADDR : S_DONE;
                        end
                    end
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                rd_fsm_done = 1'b1;
                state_next  = S_IDLE;
            end
            S_ERROR: begin
                busy   = 1'b1;
                rready = draining;
                if (!draining && clear_error) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (reset) begin
            state_next   = S_IDLE;
            desc_rd_en   = 1'b0;
            arvalid      = 1'b0;
            araddr       = '0;
            arlen        = '0;
            rready       = 1'b0;
            fifo_wr_en   = 1'b0;
            fifo_wr_data = '0;
            rd_fsm_done  = 1'b0;
            busy         = 1'b0;
        end
    end

    // Descriptor progress, beat tracking and error bookkeeping. After a bad
    // beat that is not rlast, draining stays set so the rest of the burst
    // is swallowed. A new burst or a return to IDLE cannot start until that
    // burst has ended.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            beat_idx  <= '0;
            exp_last  <= '0;
            draining  <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (desc_rd_en) begin
                        cur_addr  <= desc_src_addr & ~ADDR_W'(BPB - 1);
                        remaining <= desc_length;
                    end
                end
                S_ADDR: begin
                    if (arready) begin
                        cur_addr  <= cur_addr + (ADDR_W'(burst) << BPB_LOG2);
                        remaining <= remaining - LENGTH_W'(burst);
                        beat_idx  <= '0;
                        exp_last  <= burst_arlen;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        if (beat_bad) begin
                            error_q  <= 1'b1;
                            draining <= !rlast;
                        end else begin
                            beat_idx <= beat_idx + 8'd1;
                        end
                    end
                end
                S_ERROR: begin
                    if (draining) begin
                        if (accept && rlast) begin
                            draining <= 1'b0;
                        end
                    end else if (clear_error) begin
                        error_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Performance counters are cleared by the descriptor pop and saturate
    // at all-ones. They keep their final values after DONE so the CSR block
    // can read them.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_clk_cnt  <= '0;
            rd_beat_cnt <= '0;
        end else if (desc_rd_en) begin
            rd_clk_cnt  <= '0;
            rd_beat_cnt <= '0;
        end else begin
            if ((state == S_ADDR || state == S_DATA) && rd_clk_cnt != '1) begin
                rd_clk_cnt <= rd_clk_cnt + PERF_CNTR_W'(1);
            end
            if (fifo_wr_en && rd_beat_cnt != '1) begin
                rd_beat_cnt <= rd_beat_cnt + PERF_CNTR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dma_read_src_engine.sv
// tb_dma_read_src_engine
//
// Directed testbench for dma_read_src_engine. Inputs are driven on the
// falling clock edge and outputs are sampled 1 time unit later. Each
// comparison is an immediate assertion against a value worked out by hand.

module tb_dma_read_src_engine;

    localparam int DATA_W      = 512;
    localparam int ADDR_W      = 64;
    localparam int LENGTH_W    = 24;
    localparam int PERF_CNTR_W = 32;

    localparam logic [511:0] ONE  = 512'd1;
    localparam logic [511:0] ZERO = 512'd0;

    logic                   clk;
    logic                   reset;
    logic                   desc_not_empty;
    logic                   desc_go;
    logic [ADDR_W-1:0]      desc_src_addr;
    logic [LENGTH_W-1:0]    desc_length;
    logic                   desc_rd_en;
    logic                   arvalid;
    logic                   arready;
    logic [ADDR_W-1:0]      araddr;
    logic [7:0]             arlen;
    logic [2:0]             arsize;
    logic [1:0]             arburst;
    logic                   rvalid;
    logic                   rready;
    logic [DATA_W-1:0]      rdata;
    logic [1:0]             rresp;
    logic                   rlast;
    logic                   fifo_wr_en;
    logic [DATA_W-1:0]      fifo_wr_data;
    logic                   fifo_full;
    logic                   rd_fsm_done;
    logic                   busy;
    logic                   error;
    logic                   clear_error;
    logic [PERF_CNTR_W-1:0] rd_clk_cnt;
    logic [PERF_CNTR_W-1:0] rd_beat_cnt;

    int vectorCount     = 0;
    int miscompareCount = 0;

    dma_read_src_engine #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LENGTH_W   (LENGTH_W),
        .PERF_CNTR_W(PERF_CNTR_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .desc_not_empty(desc_not_empty),
        .desc_go       (desc_go),
        .desc_src_addr (desc_src_addr),
        .desc_length   (desc_length),
        .desc_rd_en    (desc_rd_en),
        .arvalid       (arvalid),
        .arready       (arready),
        .araddr        (araddr),
        .arlen         (arlen),
        .arsize        (arsize),
        .arburst       (arburst),
        .rvalid        (rvalid),
        .rready        (rready),
        .rdata         (rdata),
        .rresp         (rresp),
        .rlast         (rlast),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_wr_data  (fifo_wr_data),
        .fifo_full     (fifo_full),
        .rd_fsm_done   (rd_fsm_done),
        .busy          (busy),
        .error         (error),
        .clear_error   (clear_error),
        .rd_clk_cnt    (rd_clk_cnt),
        .rd_beat_cnt   (rd_beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bound on the whole run in case the design stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    // Beat payload with a unique per-index pattern, used to check order.
    function automatic logic [511:0] pat(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(i);
        return {16{w}};
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] observed,
                               input logic [511:0] expected);
        vectorCount++;
        assert (observed === expected) else begin
            miscompareCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present a descriptor for one cycle and check the pop strobe.
    task automatic applyStimulus(input logic [63:0] addr, input logic [23:0] len);
        @(negedge clk);
        desc_not_empty = 1'b1;
        desc_go        = 1'b1;
        desc_src_addr  = addr;
        desc_length    = len;
        #1;
        checkOutput("desc_rd_en", 512'(desc_rd_en), ONE);
        checkOutput("busy_at_pop", 512'(busy), ZERO);
        @(negedge clk);
        desc_not_empty = 1'b0;
        desc_go        = 1'b0;
    endtask

    // Hold off arready for waitCycles, checking the AR fields stay stable.
    task automatic expectAr(input logic [63:0] addr, input logic [7:0] len, input int waitCycles);
        for (int w = 0; w <= waitCycles; w++) begin
            arready = (w == waitCycles);
            #1;
            checkOutput("arvalid", 512'(arvalid), ONE);
            checkOutput("araddr", 512'(araddr), 512'(addr));
            checkOutput("arlen", 512'(arlen), 512'(len));
            checkOutput("arsize", 512'(arsize), 512'(3'd6));
            checkOutput("arburst", 512'(arburst), 512'(2'b01));
            checkOutput("rready_in_addr", 512'(rready), ZERO);
            @(negedge clk);
        end
        arready = 1'b0;
    endtask

    // Feed n OKAY beats back to back. rlast goes on the final one only when
    // endsBurst is set.
    task automatic dataBeats(input int first, input int n, input bit endsBurst);
        for (int i = 0; i < n; i++) begin
            rvalid = 1'b1;
            rresp  = 2'b00;
            rdata  = pat(first + i);
            rlast  = (i == n - 1) && endsBurst;
            #1;
            checkOutput("rready", 512'(rready), ONE);
            checkOutput("fifo_wr_en", 512'(fifo_wr_en), ONE);
            checkOutput("fifo_wr_data", fifo_wr_data, pat(first + i));
            @(negedge clk);
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rdata  = '0;
    endtask

    // DONE cycle, then the cycle back in IDLE with counters held.
    task automatic checkDone(input int beats, input int clks);
        #1;
        checkOutput("rd_fsm_done", 512'(rd_fsm_done), ONE);
        checkOutput("busy_in_done", 512'(busy), ONE);
        checkOutput("arvalid_in_done", 512'(arvalid), ZERO);
        checkOutput("rd_beat_cnt", 512'(rd_beat_cnt), 512'(beats));
        checkOutput("rd_clk_cnt", 512'(rd_clk_cnt), 512'(clks));
        @(negedge clk);
        #1;
        checkOutput("rd_fsm_done_after", 512'(rd_fsm_done), ZERO);
        checkOutput("busy_after", 512'(busy), ZERO);
        checkOutput("rd_beat_cnt_hold", 512'(rd_beat_cnt), 512'(beats));
        checkOutput("rd_clk_cnt_hold", 512'(rd_clk_cnt), 512'(clks));
    endtask

    initial begin
        reset          = 1'b1;
        desc_not_empty = 1'b0;
        desc_go        = 1'b0;
        desc_src_addr  = '0;
        desc_length    = '0;
        arready        = 1'b0;
        rvalid         = 1'b0;
        rdata          = '0;
        rresp          = 2'b00;
        rlast          = 1'b0;
        fifo_full      = 1'b0;
        clear_error    = 1'b0;

        // Reset state.
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("rst_busy", 512'(busy), ZERO);
        checkOutput("rst_error", 512'(error), ZERO);
        checkOutput("rst_arvalid", 512'(arvalid), ZERO);
        checkOutput("rst_rready", 512'(rready), ZERO);
        checkOutput("rst_done", 512'(rd_fsm_done), ZERO);
        checkOutput("rst_clk_cnt", 512'(rd_clk_cnt), ZERO);
        checkOutput("rst_beat_cnt", 512'(rd_beat_cnt), ZERO);
        reset = 1'b0;

        // Single 4-beat burst: ADDR 1 cycle + DATA 4 cycles.
        $display("[TB] single burst 0x1000 x4");
        applyStimulus(64'h1000, 24'd4);
        expectAr(64'h1000, 8'd3, 0);
        dataBeats(0, 4, 1'b1);
        checkDone(4, 5);

        // 100 beats split at 0x2000: 64 + 36, clocks 1+64+1+36.
        $display("[TB] split burst 0x1000 x100");
        applyStimulus(64'h1000, 24'd100);
        expectAr(64'h1000, 8'd63, 0);
        dataBeats(0, 64, 1'b1);
        expectAr(64'h2000, 8'd35, 0);
        dataBeats(64, 36, 1'b1);
        checkDone(100, 102);

        // Unaligned low bits dropped; 2 beats to page end, then 8.
        // Clocks: 3 (AR wait 2) + 2 + 1 + 8.
        $display("[TB] page edge 0x1FA5 x10");
        applyStimulus(64'h1FA5, 24'd10);
        expectAr(64'h1F80, 8'd1, 2);
        dataBeats(0, 2, 1'b1);
        expectAr(64'h2000, 8'd7, 0);
        dataBeats(2, 8, 1'b1);
        checkDone(10, 14);

        // fifo_full stall of 5 cycles mid-burst. Clocks: 1 + 3 + 5 + 5.
        $display("[TB] fifo_full stall");
        applyStimulus(64'h3000, 24'd8);
        expectAr(64'h3000, 8'd7, 0);
        dataBeats(0, 3, 1'b0);
        for (int s = 0; s < 5; s++) begin
            fifo_full = 1'b1;
            rvalid    = 1'b1;
            rdata     = pat(3);
            rlast     = 1'b0;
            #1;
            checkOutput("stall_rready", 512'(rready), ZERO);
            checkOutput("stall_wr_en", 512'(fifo_wr_en), ZERO);
            @(negedge clk);
        end
        fifo_full = 1'b0;
        dataBeats(3, 5, 1'b1);
        checkDone(8, 14);

        // SLVERR on the second beat of four; the rest is drained, not written.
        $display("[TB] slverr drain");
        applyStimulus(64'h4000, 24'd4);
        expectAr(64'h4000, 8'd3, 0);
        dataBeats(0, 1, 1'b0);
        rvalid = 1'b1;
        rdata  = pat(1);
        rresp  = 2'b10;
        #1;
        checkOutput("err_beat_wr_en", 512'(fifo_wr_en), ZERO);
        checkOutput("err_beat_rready", 512'(rready), ONE);
        @(negedge clk);
        rresp       = 2'b00;
        rdata       = pat(2);
        clear_error = 1'b1;
        #1;
        checkOutput("err_flag", 512'(error), ONE);
        checkOutput("err_busy", 512'(busy), ONE);
        checkOutput("drain_rready", 512'(rready), ONE);
        checkOutput("drain_wr_en", 512'(fifo_wr_en), ZERO);
        @(negedge clk);
        rdata = pat(3);
        rlast = 1'b1;
        #1;
        checkOutput("drain_last_rready", 512'(rready), ONE);
        checkOutput("drain_last_wr_en", 512'(fifo_wr_en), ZERO);
        checkOutput("err_no_done", 512'(rd_fsm_done), ZERO);
        @(negedge clk);
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        checkOutput("drained_rready", 512'(rready), ZERO);
        checkOutput("err_held", 512'(error), ONE);
        checkOutput("err_no_done2", 512'(rd_fsm_done), ZERO);
        @(negedge clk);
        #1;
        checkOutput("err_cleared", 512'(error), ZERO);
        checkOutput("err_idle_busy", 512'(busy), ZERO);
        checkOutput("err_beat_cnt", 512'(rd_beat_cnt), ONE);
        clear_error = 1'b0;

        // Zero-length descriptor goes straight to DONE.
        $display("[TB] zero length");
        applyStimulus(64'h6000, 24'd0);
        checkDone(0, 0);

        // Reset in the middle of DATA.
        $display("[TB] reset mid-data");
        applyStimulus(64'h5000, 24'd4);
        expectAr(64'h5000, 8'd3, 0);
        dataBeats(0, 1, 1'b0);
        rvalid = 1'b1;
        rdata  = pat(1);
        reset  = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("mid_rst_busy", 512'(busy), ZERO);
        checkOutput("mid_rst_rready", 512'(rready), ZERO);
        checkOutput("mid_rst_wr_en", 512'(fifo_wr_en), ZERO);
        checkOutput("mid_rst_wr_data", fifo_wr_data, ZERO);
        checkOutput("mid_rst_arvalid", 512'(arvalid), ZERO);
        checkOutput("mid_rst_beat_cnt", 512'(rd_beat_cnt), ZERO);
        checkOutput("mid_rst_clk_cnt", 512'(rd_clk_cnt), ZERO);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("idle_ignores_rvalid", 512'(rready), ZERO);
        checkOutput("idle_no_write", 512'(fifo_wr_en), ZERO);
        rvalid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompareCount);
        $finish;
    end

endmodule
